// File: rtl/kamacore_stage_id_hs.sv
// Handshaked instruction-decode stage with an internal register file.
// Accepts RV32 words from IF over valid/ready, reads and bypasses operands, builds the
// immediate, and holds the decoded result in a single ID->EX slot with its own valid/ready.
// A load in the slot whose rd feeds the incoming word inserts one bubble.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   if_valid/if_ready        IF-side handshake; if_instruction is the RV32 word
//   ex_valid/ex_ready        EX-side handshake for the registered slot
//   ex_instruction, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd_a, ex_is_load
//                            registered slot contents
//   flush                    drop the IF word and empty the slot
//   writeback_rd_we/_a/_data register-file write port (also bypassed to the read ports)
//   stall_count              saturating count of load-use bubble cycles
module kamacore_stage_id_hs #(
  parameter int unsigned CPU_WIDTH       = 32,
  parameter int unsigned REG_COUNT       = 32,
  parameter int unsigned STALL_CNT_WIDTH = 16,
  localparam int unsigned REG_ADDR_WIDTH = $clog2(REG_COUNT)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       if_valid,
  output logic                       if_ready,
  input  logic [31:0]                if_instruction,
  output logic                       ex_valid,
  input  logic                       ex_ready,
  output logic [31:0]                ex_instruction,
  output logic [CPU_WIDTH-1:0]       ex_rs1_data,
  output logic [CPU_WIDTH-1:0]       ex_rs2_data,
  output logic [CPU_WIDTH-1:0]       ex_imm,
  output logic [REG_ADDR_WIDTH-1:0]  ex_rd_a,
  output logic                       ex_is_load,
  input  logic                       flush,
  input  logic                       writeback_rd_we,
  input  logic [REG_ADDR_WIDTH-1:0]  writeback_rd_a,
  input  logic [CPU_WIDTH-1:0]       writeback_rd_data,
  output logic [STALL_CNT_WIDTH-1:0] stall_count
);

  localparam int unsigned RfDepth = 2 ** REG_ADDR_WIDTH;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;

  // Register file: x0 has no storage; unused addresses (non power-of-two counts) read 0.
  logic [CPU_WIDTH-1:0] regs_q [1:REG_COUNT-1];
  logic [CPU_WIDTH-1:0] rf_rd  [RfDepth];

  for (genvar i = 1; i < REG_COUNT; i++) begin : g_rf
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        regs_q[i] <= '0;
      end else if (writeback_rd_we && writeback_rd_a == REG_ADDR_WIDTH'(i)) begin
        regs_q[i] <= writeback_rd_data;
      end
    end
  end

  for (genvar i = 0; i < RfDepth; i++) begin : g_rd
    if (i == 0 || i >= REG_COUNT) begin : g_zero
      assign rf_rd[i] = '0;
    end else begin : g_reg
      assign rf_rd[i] = regs_q[i];
    end
  end

  // Decode of the incoming word
  logic [6:0]                opcode;
  logic [REG_ADDR_WIDTH-1:0] rs1, rs2, rd;
  logic [CPU_WIDTH-1:0]      rs1_data, rs2_data, imm;
  logic [31:0]               imm32;
  logic                      uses_rs1, uses_rs2;

  assign opcode = if_instruction[6:0];
  assign rs1    = REG_ADDR_WIDTH'(if_instruction[19:15]);
  assign rs2    = REG_ADDR_WIDTH'(if_instruction[24:20]);
  assign rd     = REG_ADDR_WIDTH'(if_instruction[11:7]);

  always_comb begin
    imm32    = '0;
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    case (opcode)
      OpLoad, OpOpImm, OpJalr: imm32 = {{20{if_instruction[31]}}, if_instruction[31:20]};
      OpStore: begin
        imm32    = {{20{if_instruction[31]}}, if_instruction[31:25], if_instruction[11:7]};
        uses_rs2 = 1'b1;
      end
      OpBranch: begin
        imm32    = {{19{if_instruction[31]}}, if_instruction[31], if_instruction[7],
                    if_instruction[30:25], if_instruction[11:8], 1'b0};
        uses_rs2 = 1'b1;
      end
      OpOp: uses_rs2 = 1'b1;
      OpLui, OpAuipc: begin
        imm32    = {if_instruction[31:12], 12'h000};
        uses_rs1 = 1'b0;
      end
      OpJal: begin
        imm32    = {{11{if_instruction[31]}}, if_instruction[31], if_instruction[19:12],
                    if_instruction[20], if_instruction[30:21], 1'b0};
        uses_rs1 = 1'b0;
      end
      default: ;
    endcase
  end

  assign imm = CPU_WIDTH'($signed(imm32));

  // Same-cycle writeback wins over the stored value
  always_comb begin
    rs1_data = rf_rd[rs1];
    rs2_data = rf_rd[rs2];
    if (writeback_rd_we && writeback_rd_a == rs1 && rs1 != '0) rs1_data = writeback_rd_data;
    if (writeback_rd_we && writeback_rd_a == rs2 && rs2 != '0) rs2_data = writeback_rd_data;
  end

  // Slot registers
  logic                       ex_valid_q, ex_is_load_q;
  logic [31:0]                ex_instr_q;
  logic [CPU_WIDTH-1:0]       ex_rs1_q, ex_rs2_q, ex_imm_q;
  logic [REG_ADDR_WIDTH-1:0]  ex_rd_q;
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_q;
  logic                       hazard, advance;

  assign advance  = !ex_valid_q || ex_ready;
  assign hazard   = if_valid && ex_valid_q && ex_is_load_q && ex_rd_q != '0 &&
                    ((uses_rs1 && rs1 == ex_rd_q) || (uses_rs2 && rs2 == ex_rd_q));
  assign if_ready = flush || (advance && !hazard);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q   <= 1'b0;
      ex_is_load_q <= 1'b0;
      ex_instr_q   <= '0;
      ex_rs1_q     <= '0;
      ex_rs2_q     <= '0;
      ex_imm_q     <= '0;
      ex_rd_q      <= '0;
      stall_cnt_q  <= '0;
    end else if (flush) begin
      ex_valid_q <= 1'b0;
    end else if (advance) begin
      if (hazard) begin
        ex_valid_q <= 1'b0;
        if (stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + STALL_CNT_WIDTH'(1);
      end else begin
        ex_valid_q <= if_valid;
        if (if_valid) begin
          ex_instr_q   <= if_instruction;
          ex_rs1_q     <= rs1_data;
          ex_rs2_q     <= rs2_data;
          ex_imm_q     <= imm;
          ex_rd_q      <= rd;
          ex_is_load_q <= (opcode == OpLoad);
        end
      end
    end
  end

  assign ex_valid       = ex_valid_q;
  assign ex_instruction = ex_instr_q;
  assign ex_rs1_data    = ex_rs1_q;
  assign ex_rs2_data    = ex_rs2_q;
  assign ex_imm         = ex_imm_q;
  assign ex_rd_a        = ex_rd_q;
  assign ex_is_load     = ex_is_load_q;
  assign stall_count    = stall_cnt_q;

endmodule

// File: tb/tb_kamacore_stage_id_hs.sv
module tb_kamacore_stage_id_hs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid = 1'b0, if_ready;
  logic [31:0] if_instruction = '0;
  logic        ex_valid, ex_ready = 1'b1;
  logic [31:0] ex_instruction, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rd_a;
  logic        ex_is_load;
  logic        flush = 1'b0;
  logic        writeback_rd_we = 1'b0;
  logic [4:0]  writeback_rd_a = '0;
  logic [31:0] writeback_rd_data = '0;
  logic [15:0] stall_count;

  int total = 0;
  int bad   = 0;

  kamacore_stage_id_hs dut (
    .clk               (clk),
    .rst               (rst),
    .if_valid          (if_valid),
    .if_ready          (if_ready),
    .if_instruction    (if_instruction),
    .ex_valid          (ex_valid),
    .ex_ready          (ex_ready),
    .ex_instruction    (ex_instruction),
    .ex_rs1_data       (ex_rs1_data),
    .ex_rs2_data       (ex_rs2_data),
    .ex_imm            (ex_imm),
    .ex_rd_a           (ex_rd_a),
    .ex_is_load        (ex_is_load),
    .flush             (flush),
    .writeback_rd_we   (writeback_rd_we),
    .writeback_rd_a    (writeback_rd_a),
    .writeback_rd_data (writeback_rd_data),
    .stall_count       (stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural reference ----------------
  logic [31:0] m_rf [32];
  logic        m_valid = 1'b0, m_load = 1'b0;
  logic [31:0] m_ins = '0, m_rs1 = '0, m_rs2 = '0, m_imm = '0;
  int          m_rd = 0, m_stall = 0;

  initial for (int i = 0; i < 32; i++) m_rf[i] = '0;

  function automatic logic [31:0] m_read(input int r);
    if (r == 0) return 32'h0;
    if (writeback_rd_we && int'(writeback_rd_a) == r) return writeback_rd_data;
    return m_rf[r];
  endfunction

  function automatic logic [31:0] m_immgen(input logic [31:0] w);
    logic [6:0] op;
    op = w[6:0];
    case (op)
      7'b0000011, 7'b0010011, 7'b1100111: return 32'(int'($signed(w[31:20])));
      7'b0100011: return 32'(int'($signed({w[31:25], w[11:7]})));
      7'b1100011: return 32'(int'($signed({w[31], w[7], w[30:25], w[11:8]})) * 2);
      7'b0110111, 7'b0010111: return {w[31:12], 12'h000};
      7'b1101111: return 32'(int'($signed({w[31], w[19:12], w[20], w[30:21]})) * 2);
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_hazard();
    logic [6:0] op;
    bit r1, r2;
    op = if_instruction[6:0];
    r1 = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
    r2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
    if (!(if_valid && m_valid && m_load && m_rd != 0)) return 1'b0;
    return (r1 && int'(if_instruction[19:15]) == m_rd) ||
           (r2 && int'(if_instruction[24:20]) == m_rd);
  endfunction

  function automatic bit m_if_ready();
    return flush || ((!m_valid || ex_ready) && !m_hazard());
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid = 1'b0; m_load = 1'b0; m_ins = '0; m_rs1 = '0; m_rs2 = '0; m_imm = '0;
      m_rd = 0; m_stall = 0;
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
    end else begin
      bit adv, haz;
      adv = !m_valid || ex_ready;
      haz = m_hazard();
      if (flush) m_valid = 1'b0;
      else if (adv && haz) begin
        m_valid = 1'b0;
        if (m_stall < 65535) m_stall++;
      end else if (adv) begin
        m_valid = if_valid;
        if (if_valid) begin
          m_ins  = if_instruction;
          m_rs1  = m_read(int'(if_instruction[19:15]));
          m_rs2  = m_read(int'(if_instruction[24:20]));
          m_imm  = m_immgen(if_instruction);
          m_rd   = int'(if_instruction[11:7]);
          m_load = (if_instruction[6:0] == 7'b0000011);
        end
      end
      if (writeback_rd_we && writeback_rd_a != 0) m_rf[writeback_rd_a] = writeback_rd_data;
    end
  end

  // Compare process: every negative edge
  always @(negedge clk) begin
    chk("if_ready", if_ready, m_if_ready());
    chk("ex_valid", ex_valid, m_valid);
    chk("stall_count", stall_count, 64'(m_stall));
    if (m_valid) begin
      chk("ex_instruction", ex_instruction, m_ins);
      chk("ex_rs1_data", ex_rs1_data, m_rs1);
      chk("ex_rs2_data", ex_rs2_data, m_rs2);
      chk("ex_imm", ex_imm, m_imm);
      chk("ex_rd_a", ex_rd_a, 64'(m_rd));
      chk("ex_is_load", ex_is_load, m_load);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic [31:0] ins, input logic rdy, input logic fl,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
    if_valid = v; if_instruction = ins; ex_ready = rdy; flush = fl;
    writeback_rd_we = we; writeback_rd_a = wa; writeback_rd_data = wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_ins();
    logic [6:0] ops [10];
    logic [31:0] w;
    ops = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011, 7'b1100011,
            7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b0001111};
    w = $urandom;
    w[6:0]   = ops[$urandom_range(0, 9)];
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    return w;
  endfunction

  initial begin
    #1 rst = 1'b0;
    #2;
    chk("reset ex_valid", ex_valid, 0);
    chk("reset stall_count", stall_count, 0);
    step();
    rst = 1'b1;

    // write x5, then read it
    drive(0, 0, 1, 0, 1, 5, 32'hDEADBEEF);
    step();
    drive(1, 32'h000280B3, 1, 0, 0, 0, 0);
    step();
    chk("rd after wr rs1", ex_rs1_data, 32'hDEADBEEF);
    chk("rd after wr rs2", ex_rs2_data, 0);
    // same-cycle bypass
    drive(1, 32'h000300B3, 1, 0, 1, 6, 32'hCAFEF00D);
    step();
    chk("bypass rs1", ex_rs1_data, 32'hCAFEF00D);
    // write to x0 is dropped
    drive(0, 0, 1, 0, 1, 0, 32'h1234);
    step();
    drive(1, 32'h000000B3, 1, 0, 0, 0, 0);
    step();
    chk("x0 read", ex_rs1_data, 0);

    // load-use
    drive(1, 32'h00012183, 1, 0, 0, 0, 0);
    step();
    drive(1, 32'h00318233, 1, 0, 0, 0, 0);
    #1 chk("load-use if_ready", if_ready, 0);
    step();
    chk("bubble ex_valid", ex_valid, 0);
    chk("bubble stall_count", stall_count, 1);
    chk("post-bubble if_ready", if_ready, 1);
    step();
    chk("post-bubble instr", ex_instruction, 32'h00318233);

    // no hazard after load
    drive(1, 32'h00012183, 1, 0, 0, 0, 0);
    step();
    drive(1, 32'h123451B7, 1, 0, 0, 0, 0);
    #1 chk("lui after lw if_ready", if_ready, 1);
    step();
    chk("lui after lw stall", stall_count, 1);
    chk("lui imm", ex_imm, 32'h12345000);
    drive(1, 32'h00012183, 1, 0, 0, 0, 0);
    step();
    drive(1, 32'h00138313, 1, 0, 0, 0, 0);
    step();
    chk("addi after lw valid", ex_valid, 1);
    chk("addi after lw stall", stall_count, 1);
    chk("addi imm", ex_imm, 1);

    // immediates
    drive(1, 32'hFE000EE3, 1, 0, 0, 0, 0);
    step();
    chk("beq imm", ex_imm, 32'hFFFFFFFC);
    drive(1, 32'h123452B7, 1, 0, 0, 0, 0);
    step();
    chk("lui2 imm", ex_imm, 32'h12345000);
    drive(1, 32'hFFF00093, 1, 0, 0, 0, 0);
    step();
    chk("addi -1 imm", ex_imm, 32'hFFFFFFFF);

    // backpressure then flush
    drive(1, 32'h123452B7, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp if_ready", if_ready, 0);
      chk("bp hold instr", ex_instruction, 32'hFFF00093);
      step();
    end
    drive(1, 32'h123452B7, 0, 1, 0, 0, 0);
    #1 chk("flush if_ready", if_ready, 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    #1 chk("flush ex_valid", ex_valid, 0);
    chk("flush then if_ready", if_ready, 1);

    // reset mid-operation
    drive(1, 32'h000280B3, 1, 0, 0, 0, 0);
    step();
    chk("pre-reset valid", ex_valid, 1);
    #1 rst = 1'b0;
    #1 chk("async reset ex_valid", ex_valid, 0);
    chk("async reset stall", stall_count, 0);
    #1 rst = 1'b1;
    step();
    chk("regs cleared", ex_rs1_data, 0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 3) != 0, rand_ins(), $urandom_range(0, 9) < 7,
            $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 7)), $urandom);
      step();
    end

    drive(0, 0, 1, 0, 0, 0, 0);
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
